tcb_lite_lib_memory: RTL and testbench
======================================

TCB_LITE_LIB_MEMORY -- requirements
Module: tcb_lite_lib_memory

Interface
REQ-001 Parameter DLY, default 1: response delay in clock cycles from request transfer to response; legal range 1..4.
REQ-002 Parameter HLD, default 1'b0: 1 = hold last response between responses, 0 = drive zeros when no response is due.
REQ-003 Parameter ADR, default 32: address width.
REQ-004 Parameter DAT, default 32: data width; only 32 or 64; BYT = DAT/8 derived.
REQ-005 Parameter DEP, default 256: memory depth in DAT-wide words; power of two, at least 2.
REQ-006 Port clk, input, 1 bit: single clock; all state is rising-edge triggered.
REQ-007 Port rst, input, 1 bit: reset, asynchronous assertion, active-low (0 = reset).
REQ-008 Port vld, input, 1 bit: handshake valid from manager.
REQ-009 Port rdy, output, 1 bit: handshake ready to manager.
REQ-010 Port req_wen, input, 1 bit: write enable (0 = read, 1 = write).
REQ-011 Port req_adr, input, ADR bits: byte address; word index = req_adr[log2(BYT)+log2(DEP)-1 : log2(BYT)].
REQ-012 Port req_byt, input, BYT bits: byte enable (byte-enable bus mode only).
REQ-013 Port req_wdt, input, DAT bits: write data.
REQ-014 Port rsp_rdt, output, DAT bits: read data.
REQ-015 Port rsp_err, output, 1 bit: bus error.

Function
REQ-016 Transfer occurs on a rising clk edge with vld=1 and rdy=1; no other condition starts an access.
REQ-017 rdy is a registered output: 0 while rst=0, 1 from the first rising edge after rst deasserts, then constant 1.
REQ-018 Write transfer: each byte lane k with req_byt[k]=1 is stored at the addressed word on the transfer edge; lanes with req_byt[k]=0 are unchanged.
REQ-019 Read transfer: the addressed word is sampled on the transfer edge, with all BYT lanes returned regardless of req_byt.
REQ-020 Response for a transfer at edge N appears on rsp_rdt/rsp_err during the cycle following edge N+DLY-1, i.e. exactly DLY cycles after the transfer.
REQ-021 Responses are produced through a DLY-stage pipeline carrying a valid bit, rdt and err; back-to-back transfers every cycle are accepted, and responses return in order.
REQ-022 A write response returns rsp_rdt = 0.
REQ-023 Read-after-write to the same word on consecutive transfers returns the newly written data; a read and write never complete on the same edge.
REQ-024 When no response is due, rsp_rdt/rsp_err are 0 if HLD=0; if HLD=1, they hold the most recent response values.
REQ-025 req_adr bits below log2(BYT) are ignored; no misalignment error is generated.

Reset
REQ-026 rst=0 asynchronously clears rdy, all pipeline valid bits, pipeline data, rsp_rdt and rsp_err to 0.
REQ-027 Reset mid-operation discards all in-flight responses; none appear after reset release.
REQ-028 Memory contents are not reset and persist across reset.

Configuration
REQ-029 Macro TCB_LITE_MEMORY_ERR_EN enables address range checking.
REQ-030 With TCB_LITE_MEMORY_ERR_EN defined:
- any transfer whose req_adr bits above the word index are non-zero is out of range;
- an out-of-range transfer returns rsp_err=1 and rsp_rdt=0 after DLY cycles;
- an out-of-range write does not modify memory.
REQ-031 Without TCB_LITE_MEMORY_ERR_EN, upper address bits are ignored (address wraps modulo DEP words), and rsp_err is constantly 0.

Verification
REQ-032 Reset: hold rst=0 for 3 cycles, then release -> rdy=0, rsp_rdt=0 and rsp_err=0 during reset; rdy=1 one edge after release.
REQ-033 DLY=2: write 0xDEADBEEF to address 0x10 with byt=4'b1111, then read 0x10 on the next cycle -> read response is 0xDEADBEEF, rsp_err=0, two cycles after the read transfer.
REQ-034 Partial write: write 0x11223344 to address 0x20 with byt=4'b0101 over prior content 0xAAAAAAAA, then read -> 0xAA22AA44.
REQ-035 DLY=3, HLD=0: 4 back-to-back reads of addresses 0x0, 0x4, 0x8 and 0xC -> 4 consecutive in-order responses starting 3 cycles after the first transfer, then rsp_rdt=0; repeat with HLD=1 -> last value is held.
REQ-036 TCB_LITE_MEMORY_ERR_EN defined, DEP=256, DAT=32: write to 0x400, then read 0x400 -> both responses have rsp_err=1, the read returns 0, and word 0 is unchanged.
REQ-037 Mid-operation reset: issue a read at DLY=4, assert rst 2 cycles later -> no response ever appears after release (rsp_rdt=0 with HLD=0), and memory data written earlier is still readable.

Source files
------------

// File: rtl/tcb_lite_lib_memory.sv
// ============================================================================
// Module   : tcb_lite_lib_memory
// Brief    : TCB-Lite byte-enabled memory with a DLY-stage response pipeline.
//            Optional address range checking: define TCB_LITE_MEMORY_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcb_lite_lib_memory #(
    parameter int unsigned DLY = 1,
    parameter bit          HLD = 1'b0,
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter int unsigned DEP = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld,
    output logic                 rdy,
    input  logic                 req_wen,
    input  logic [ADR-1:0]       req_adr,
    input  logic [DAT/8-1:0]     req_byt,
    input  logic [DAT-1:0]       req_wdt,
    output logic [DAT-1:0]       rsp_rdt,
    output logic                 rsp_err
);

    localparam int unsigned BYT = DAT / 8;
    localparam int unsigned OFF = $clog2(BYT);
    localparam int unsigned IDX = $clog2(DEP);

    logic                 rdy_q;
    logic                 rdy_d;
    logic [DAT-1:0]       mem_q [DEP];

    logic [DLY-1:0]       pvld_q;
    logic [DLY-1:0]       pvld_d;
    logic [DLY-1:0]       perr_q;
    logic [DLY-1:0]       perr_d;
    logic [DAT-1:0]       prdt_q [DLY];
    logic [DAT-1:0]       prdt_d [DLY];

    logic                 w_xfer;
    logic                 w_oor;
    logic                 w_wr;
    logic [IDX-1:0]       w_idx;
    logic                 unused_adr;

    assign w_xfer     = vld & rdy_q;
    assign w_idx      = req_adr[OFF+IDX-1:OFF];
    assign w_wr       = w_xfer & req_wen & ~w_oor;
    assign unused_adr = ^req_adr;
    assign rdy        = rdy_q;

`ifdef TCB_LITE_MEMORY_ERR_EN
    generate
        if (ADR > OFF + IDX) begin : g_oor
            assign w_oor = |req_adr[ADR-1:OFF+IDX];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate
`else
    assign w_oor = 1'b0;
`endif

    always_comb begin
        rdy_d = 1'b1;
    end

    // Memory is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < BYT; b++) begin
                if (req_byt[b]) begin
                    mem_q[w_idx][8*b +: 8] <= req_wdt[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        pvld_d    = '0;
        perr_d    = '0;
        for (int i = 0; i < DLY; i++) begin
            prdt_d[i] = '0;
        end
        pvld_d[0] = w_xfer;
        perr_d[0] = w_xfer & w_oor;
        prdt_d[0] = (w_xfer & ~req_wen & ~w_oor) ? mem_q[w_idx] : '0;
        for (int i = 1; i < DLY; i++) begin
            pvld_d[i] = pvld_q[i-1];
            perr_d[i] = perr_q[i-1];
            prdt_d[i] = prdt_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q  <= 1'b0;
            pvld_q <= '0;
            perr_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                prdt_q[i] <= '0;
            end
        end else begin
            rdy_q  <= rdy_d;
            pvld_q <= pvld_d;
            perr_q <= perr_d;
            for (int i = 0; i < DLY; i++) begin
                prdt_q[i] <= prdt_d[i];
            end
        end
    end

    generate
        if (HLD) begin : g_hld
            logic [DAT-1:0] hrdt_q;
            logic [DAT-1:0] hrdt_d;
            logic           herr_q;
            logic           herr_d;

            always_comb begin
                hrdt_d = hrdt_q;
                herr_d = herr_q;
                if (pvld_q[DLY-1]) begin
                    hrdt_d = prdt_q[DLY-1];
                    herr_d = perr_q[DLY-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hrdt_q <= '0;
                    herr_q <= 1'b0;
                end else begin
                    hrdt_q <= hrdt_d;
                    herr_q <= herr_d;
                end
            end

            // Bypass the hold register so a fresh response is not a cycle late.
            assign rsp_rdt = pvld_q[DLY-1] ? prdt_q[DLY-1] : hrdt_q;
            assign rsp_err = pvld_q[DLY-1] ? perr_q[DLY-1] : herr_q;
        end else begin : g_zero
            assign rsp_rdt = pvld_q[DLY-1] ? prdt_q[DLY-1] : '0;
            assign rsp_err = pvld_q[DLY-1] & perr_q[DLY-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_tcb_lite_lib_memory.sv
// ============================================================================
// Module   : tb_tcb_lite_lib_memory
// Brief    : Directed bench; four DUTs (DLY/HLD variants) share one request bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcb_lite_lib_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld = 1'b0;
    logic        req_wen = 1'b0;
    logic [31:0] req_adr = '0;
    logic [3:0]  req_byt = '0;
    logic [31:0] req_wdt = '0;

    logic        rdy2, rdy3, rdy3h, rdy4;
    logic [31:0] rdt2, rdt3, rdt3h, rdt4;
    logic        err2, err3, err3h, err4;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] D0 = 32'h0000_1111;
    localparam logic [31:0] D1 = 32'h2222_3333;
    localparam logic [31:0] D2 = 32'h4444_5555;
    localparam logic [31:0] D3 = 32'h6666_7777;

    always #5 clk = ~clk;

    tcb_lite_lib_memory #(.DLY(2), .HLD(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy2), .req_wen(req_wen),
        .req_adr(req_adr), .req_byt(req_byt), .req_wdt(req_wdt),
        .rsp_rdt(rdt2), .rsp_err(err2));

    tcb_lite_lib_memory #(.DLY(3), .HLD(1'b0)) u_d3 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy3), .req_wen(req_wen),
        .req_adr(req_adr), .req_byt(req_byt), .req_wdt(req_wdt),
        .rsp_rdt(rdt3), .rsp_err(err3));

    tcb_lite_lib_memory #(.DLY(3), .HLD(1'b1)) u_d3h (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy3h), .req_wen(req_wen),
        .req_adr(req_adr), .req_byt(req_byt), .req_wdt(req_wdt),
        .rsp_rdt(rdt3h), .rsp_err(err3h));

    tcb_lite_lib_memory #(.DLY(4), .HLD(1'b0)) u_d4 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy4), .req_wen(req_wen),
        .req_adr(req_adr), .req_byt(req_byt), .req_wdt(req_wdt),
        .rsp_rdt(rdt4), .rsp_err(err4));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic wen, input logic [31:0] adr,
                        input logic [3:0] byt, input logic [31:0] wdt);
        vld     = 1'b1;
        req_wen = wen;
        req_adr = adr;
        req_byt = byt;
        req_wdt = wdt;
        tick();
        vld     = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) tick();
    endtask

    logic [31:0] e2  [7];
    logic [31:0] e3  [7];
    logic [31:0] e3h [7];
    logic [31:0] e4  [7];
    logic        x_err;
    logic [31:0] x_rd400;
    logic [31:0] x_w0;

    initial begin
        e2  = '{32'h0, D0, D1, D2, D3, 32'h0, 32'h0};
        e3  = '{32'h0, 32'h0, D0, D1, D2, D3, 32'h0};
        e3h = '{32'h0, 32'h0, D0, D1, D2, D3, D3};
        e4  = '{32'h0, 32'h0, 32'h0, D0, D1, D2, D3};
`ifdef TCB_LITE_MEMORY_ERR_EN
        x_err   = 1'b1;
        x_rd400 = 32'h0;
        x_w0    = D0;
`else
        x_err   = 1'b0;
        x_rd400 = 32'h5566_7788;
        x_w0    = 32'h5566_7788;
`endif

        // Reset behaviour
        rst = 1'b0;
        repeat (3) tick();
        check("rst_rdy2", rdy2, 0);
        check("rst_rdy4", rdy4, 0);
        check("rst_rdt2", rdt2, 0);
        check("rst_err2", err2, 0);
        rst = 1'b1;
        #1;
        check("rdy_before_edge", rdy2, 0);
        tick();
        check("rdy2_after_rel", rdy2, 1);
        check("rdy4_after_rel", rdy4, 1);

        // Write then read-after-write
        xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h10, 4'h0, 32'h0);
        check("d2_wr_rsp", rdt2, 0);
        idle(1);
        check("d2_raw_rdt", rdt2, 32'hDEAD_BEEF);
        check("d2_raw_err", err2, 0);
        check("d3_early", rdt3, 0);
        idle(1);
        check("d3_raw_rdt", rdt3, 32'hDEAD_BEEF);
        check("d2_idle_zero", rdt2, 0);
        idle(1);
        check("d3_idle_zero", rdt3, 0);
        check("d3h_hold", rdt3h, 32'hDEAD_BEEF);
        check("d4_raw_rdt", rdt4, 32'hDEAD_BEEF);

        // Partial byte-enable write, unaligned read address
        xfer(1'b1, 32'h20, 4'hF, 32'hAAAA_AAAA);
        xfer(1'b1, 32'h20, 4'b0101, 32'h1122_3344);
        xfer(1'b0, 32'h23, 4'b0001, 32'h0);
        idle(1);
        check("d2_partial", rdt2, 32'hAA22_AA44);

        // Back-to-back reads
        xfer(1'b1, 32'h0, 4'hF, D0);
        xfer(1'b1, 32'h4, 4'hF, D1);
        xfer(1'b1, 32'h8, 4'hF, D2);
        xfer(1'b1, 32'hC, 4'hF, D3);
        idle(4);
        for (int t = 0; t < 7; t++) begin
            if (t < 4) xfer(1'b0, 32'(4 * t), 4'hF, 32'h0);
            else idle(1);
            check($sformatf("b2b_d2_t%0d", t), rdt2, e2[t]);
            check($sformatf("b2b_d3_t%0d", t), rdt3, e3[t]);
            check($sformatf("b2b_d3h_t%0d", t), rdt3h, e3h[t]);
            check($sformatf("b2b_d4_t%0d", t), rdt4, e4[t]);
        end

        // Reset with a read in flight
        idle(4);
        xfer(1'b0, 32'h10, 4'hF, 32'h0);
        idle(2);
        rst = 1'b0;
        #1;
        check("mid_rst_rdy4", rdy4, 0);
        check("mid_rst_rdt4", rdt4, 0);
        tick();
        tick();
        check("mid_rst_d3h", rdt3h, 0);
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            check($sformatf("post_rst_d4_t%0d", t), rdt4, 0);
        end
        check("post_rst_rdy4", rdy4, 1);
        xfer(1'b0, 32'h10, 4'hF, 32'h0);
        idle(3);
        check("persist_d4", rdt4, 32'hDEAD_BEEF);
        idle(2);

        // Out-of-range (or wrapping) address
        xfer(1'b1, 32'h400, 4'hF, 32'h5566_7788);
        xfer(1'b0, 32'h400, 4'hF, 32'h0);
        check("oor_wr_err", err2, x_err);
        check("oor_wr_rdt", rdt2, 0);
        xfer(1'b0, 32'h0, 4'hF, 32'h0);
        check("oor_rd_err", err2, x_err);
        check("oor_rd_rdt", rdt2, x_rd400);
        idle(1);
        check("word0_rdt", rdt2, x_w0);
        check("word0_err", err2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
